// File: rtl/fetch_pkg.sv
// Shared constants for the fetch path: instruction layout, FSM encoding, counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int OP_W  = 2;
  localparam int FLD_W = 4;
  localparam int IR_W  = OP_W + 4 * FLD_W;
  localparam int CNT_W = 6;

  localparam logic [OP_W-1:0] OP_HALT = 2'b11;

  // FSM encoding (kept as plain constants for legacy tooling)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Field LSB positions inside the instruction word
  localparam int OP_LSB = 16;
  localparam int A_LSB  = 12;
  localparam int B_LSB  = 8;
  localparam int C_LSB  = 4;
  localparam int D_LSB  = 0;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [FLD_W-1:0] fld_a;
    logic [FLD_W-1:0] fld_b;
    logic [FLD_W-1:0] fld_c;
    logic [FLD_W-1:0] fld_d;
  } ir_t;

  // Saturating increment for the accepted-word counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Splits an instruction word into opcode and four fields; ports: ir in, opcode/fld_a..fld_d out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [IR_W-1:0]  ir,
  output logic [OP_W-1:0]  opcode,
  output logic [FLD_W-1:0] fld_a,
  output logic [FLD_W-1:0] fld_b,
  output logic [FLD_W-1:0] fld_c,
  output logic [FLD_W-1:0] fld_d
);

  assign opcode = ir[OP_LSB +: OP_W];
  assign fld_a  = ir[A_LSB  +: FLD_W];
  assign fld_b  = ir[B_LSB  +: FLD_W];
  assign fld_c  = ir[C_LSB  +: FLD_W];
  assign fld_d  = ir[D_LSB  +: FLD_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// Program-memory sequencer: PC/jump/HALT control, IR capture, valid/ready hand-off of decoded words.
// Latency: start -> instr_valid after 2 edges; one word per 2 cycles with instr_ready held high.
// Backpressure: while instr_ready is low the IR, fields and PC are frozen and instr_valid stays high.
// Ports: clk/rst; start/start_addr; address/instruction (memory side);
//        instr_valid/instr_ready/opcode/fld_a..d/pc_out/jump_en/jump_addr (downstream side);
//        busy/done/halted/instr_count (status).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 18,
  parameter int WRAP_EN = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [OP_W-1:0]    opcode,
  output logic [FLD_W-1:0]   fld_a,
  output logic [FLD_W-1:0]   fld_b,
  output logic [FLD_W-1:0]   fld_c,
  output logic [FLD_W-1:0]   fld_d,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               busy,
  output logic               done,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [ADDR_W-1:0] LAST_PC = {ADDR_W{1'b1}};

  logic [1:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               halted_q;
  logic [CNT_W-1:0]   count_q;
  logic               accept;

  // Memory read is combinational, so the address is the PC itself.
  assign address     = pc;
  assign pc_out      = ir_pc;
  assign instr_valid = (state == ST_HOLD);
  assign busy        = (state == ST_FETCH) || (state == ST_HOLD);
  assign done        = (state == ST_DONE);
  assign halted      = halted_q;
  assign instr_count = count_q;
  assign accept      = instr_valid && instr_ready;

  instr_field_split u_split (
    .ir     (ir),
    .opcode (opcode),
    .fld_a  (fld_a),
    .fld_b  (fld_b),
    .fld_c  (fld_c),
    .fld_d  (fld_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pc       <= start_addr;
            count_q  <= '0;
            halted_q <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          ir    <= instruction;
          ir_pc <= pc;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (accept) begin
            count_q <= sat_inc(count_q);
            // HALT wins over a simultaneous jump request.
            if (opcode == OP_HALT) begin
              halted_q <= 1'b1;
              state    <= ST_DONE;
            end else if (jump_en) begin
              pc    <= jump_addr;
              state <= ST_FETCH;
            end else if (pc == LAST_PC && WRAP_EN == 0) begin
              state <= ST_DONE;
            end else begin
              pc    <= pc + 1'b1;  // natural modulo 2**ADDR_W wrap
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner sequences, random vs model.
// Latency: n/a (testbench).
// Backpressure: instr_ready driven by the bench, both held and randomised.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst, start, instr_ready, jump_en;
  logic [4:0] start_addr, jump_addr;

  logic [4:0]  address0, address1, pc_out0, pc_out1;
  logic [17:0] instruction0, instruction1;
  logic [1:0]  opcode0, opcode1;
  logic [3:0]  fa0, fb0, fc0, fd0, fa1, fb1, fc1, fd1;
  logic        valid0, valid1, busy0, busy1, done0, done1, halted0, halted1;
  logic [5:0]  cnt0, cnt1;

  logic [17:0] mem [32];
  assign instruction0 = mem[address0];
  assign instruction1 = mem[address1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(5), .INSTR_W(18), .WRAP_EN(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .address(address0), .instruction(instruction0),
    .instr_valid(valid0), .instr_ready(instr_ready),
    .opcode(opcode0), .fld_a(fa0), .fld_b(fb0), .fld_c(fc0), .fld_d(fd0),
    .pc_out(pc_out0), .jump_en(jump_en), .jump_addr(jump_addr),
    .busy(busy0), .done(done0), .halted(halted0), .instr_count(cnt0)
  );

  instr_fetch_unit #(.ADDR_W(5), .INSTR_W(18), .WRAP_EN(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .address(address1), .instruction(instruction1),
    .instr_valid(valid1), .instr_ready(instr_ready),
    .opcode(opcode1), .fld_a(fa1), .fld_b(fb1), .fld_c(fc1), .fld_d(fd1),
    .pc_out(pc_out1), .jump_en(jump_en), .jump_addr(jump_addr),
    .busy(busy1), .done(done1), .halted(halted1), .instr_count(cnt1)
  );

  function automatic logic [17:0] word0();
    return {opcode0, fa0, fb0, fc0, fd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0;
    start_addr = '0; jump_addr = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_u0(input string tag);
    chk({tag, " valid"},  32'(valid0),  0);
    chk({tag, " busy"},   32'(busy0),   0);
    chk({tag, " done"},   32'(done0),   0);
    chk({tag, " halted"}, 32'(halted0), 0);
    chk({tag, " count"},  32'(cnt0),    0);
    chk({tag, " pc_out"}, 32'(pc_out0), 0);
    chk({tag, " addr"},   32'(address0), 0);
    chk({tag, " ir"},     32'(word0()), 0);
  endtask

  // Program without HALT words plus the fixed entries the directed tests rely on.
  task automatic init_mem();
    for (int i = 0; i < 32; i++)
      mem[i] = {2'($urandom_range(0, 2)), 16'($urandom)};
    mem[0]  = 18'b01_1111_0001_0001_0010;
    mem[1]  = 18'b00_0111_0010_0101_0011;
    mem[2]  = 18'b01_0000_0100_1000_0001;
    mem[3]  = 18'b10_0011_0001_0001_0010;
    mem[4]  = 18'b00_0001_0010_0011_0100;
    mem[24] = 18'b01_0011_1101_0000_0110;
    mem[31] = 18'b01_1111_1111_0001_0010;
  endtask

  task automatic wait_valid0(output int n);
    n = 0;
    while (!valid0 && n < 20) begin
      tick();
      n++;
    end
    if (!valid0) chk("wait valid timeout", 32'(valid0), 1);
  endtask

  typedef struct {
    int          stall;
    logic        jen;
    logic [4:0]  jaddr;
    logic [4:0]  exp_pc;
    logic [17:0] exp_word;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs [6];
    int n, acc, lp;
    logic [17:0] lw, held;
    int seq [$];
    int phase, mpc, mcnt, mhalt, pend;
    logic ev;
    logic [17:0] w;

    init_mem();
    do_reset();
    check_reset_u0("reset");

    // ---------------- directed vector table ----------------
    vecs[0] = '{0, 1'b0, 5'd0,  5'd0,  18'b01_1111_0001_0001_0010};
    vecs[1] = '{0, 1'b0, 5'd0,  5'd1,  18'b00_0111_0010_0101_0011};
    vecs[2] = '{0, 1'b0, 5'd0,  5'd2,  18'b01_0000_0100_1000_0001};
    vecs[3] = '{5, 1'b0, 5'd0,  5'd3,  18'b10_0011_0001_0001_0010};
    vecs[4] = '{0, 1'b1, 5'd24, 5'd4,  18'b00_0001_0010_0011_0100};
    vecs[5] = '{0, 1'b0, 5'd0,  5'd24, 18'b01_0011_1101_0000_0110};

    start_addr = 5'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("latency edge1 valid", 32'(valid0), 0);
    chk("latency edge1 busy",  32'(busy0),  1);
    tick();
    chk("latency edge2 valid", 32'(valid0), 1);

    for (int i = 0; i < 6; i++) begin
      wait_valid0(n);
      chk($sformatf("vec%0d bubble", i), n, (i == 0) ? 0 : 1);
      chk($sformatf("vec%0d pc_out", i), 32'(pc_out0), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d word", i),   32'(word0()),  32'(vecs[i].exp_word));
      held = word0();
      for (int s = 0; s < vecs[i].stall; s++) begin
        instr_ready = 1'b0;
        tick();
        chk($sformatf("vec%0d stall%0d valid", i, s), 32'(valid0), 1);
        chk($sformatf("vec%0d stall%0d ir", i, s),    32'(word0()), 32'(held));
        chk($sformatf("vec%0d stall%0d addr", i, s),  32'(address0), 32'(vecs[i].exp_pc));
      end
      instr_ready = 1'b1; jump_en = vecs[i].jen; jump_addr = vecs[i].jaddr;
      tick();
      instr_ready = 1'b0; jump_en = 1'b0;
      chk($sformatf("vec%0d valid falls", i), 32'(valid0), 0);
      chk($sformatf("vec%0d count", i), 32'(cnt0), i + 1);
    end

    // ---------------- full run, no wrap ----------------
    do_reset();
    instr_ready = 1'b1; start_addr = 5'd0; start = 1'b1;
    tick(); start = 1'b0;
    acc = 0; n = 0; lp = -1; lw = '0;
    while (!done0 && n < 200) begin
      if (valid0) begin acc++; lp = pc_out0; lw = word0(); end
      tick(); n++;
    end
    chk("full done",      32'(done0), 1);
    chk("full accepts",   acc, 32);
    chk("full count",     32'(cnt0), 32);
    chk("full last pc",   lp, 31);
    chk("full last word", 32'(lw), 32'(18'b01_1111_1111_0001_0010));
    chk("full valid low", 32'(valid0), 0);

    // ---------------- HALT ----------------
    do_reset();
    mem[2] = 18'b11_0000_0000_0000_0000;
    instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 5'd9;  // jump only taken on non-HALT words
    jump_en = 1'b0;
    start_addr = 5'd0; start = 1'b1;
    tick(); start = 1'b0;
    acc = 0; n = 0;
    while (!done0 && n < 50) begin
      if (valid0) begin
        acc++;
        jump_en = (pc_out0 == 5'd2);  // must be ignored on the HALT word
      end
      tick(); n++;
    end
    jump_en = 1'b0;
    chk("halt accepts", acc, 3);
    chk("halt halted",  32'(halted0), 1);
    chk("halt done",    32'(done0), 1);
    chk("halt count",   32'(cnt0), 3);
    chk("halt pc held", 32'(pc_out0), 2);
    instr_ready = 1'b0; start = 1'b1; start_addr = 5'd0;
    tick(); start = 1'b0;
    chk("restart halted clr", 32'(halted0), 0);
    chk("restart busy",       32'(busy0), 1);
    chk("restart count clr",  32'(cnt0), 0);
    tick();
    chk("restart valid", 32'(valid0), 1);
    chk("restart pc",    32'(pc_out0), 0);
    mem[2] = 18'b01_0000_0100_1000_0001;

    // ---------------- reset mid-HOLD, then wrap ----------------
    do_reset();
    start_addr = 5'd10; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("midhold valid", 32'(valid0), 1);
    chk("midhold pc",    32'(pc_out0), 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_u0("midhold reset");

    instr_ready = 1'b1; start_addr = 5'd30; start = 1'b1;
    tick(); start = 1'b0;
    acc = 0; n = 0;
    while (acc < 70 && n < 400) begin
      if (valid1) begin acc++; seq.push_back(int'(pc_out1)); end
      tick(); n++;
    end
    chk("wrap accepts", acc, 70);
    chk("wrap seq0", (seq.size() > 0) ? seq[0] : -1, 30);
    chk("wrap seq1", (seq.size() > 1) ? seq[1] : -1, 31);
    chk("wrap seq2", (seq.size() > 2) ? seq[2] : -1, 0);
    chk("wrap seq3", (seq.size() > 3) ? seq[3] : -1, 1);
    chk("wrap still busy",  32'(busy1), 1);
    chk("wrap count sat",   32'(cnt1), 63);
    chk("nowrap done",      32'(done0), 1);
    chk("nowrap count",     32'(cnt0), 2);
    instr_ready = 1'b0;

    // ---------------- random vs transaction model ----------------
    for (int i = 0; i < 32; i++)
      mem[i] = {(($urandom % 10) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), 16'($urandom)};
    do_reset();
    phase = 0; mpc = 0; mcnt = 0; mhalt = 0; pend = 0;
    for (int c = 0; c < 3000; c++) begin
      ev = (phase == 1) && (pend == 0);
      chk("rnd busy",   32'(busy0),   32'(phase == 1));
      chk("rnd done",   32'(done0),   32'(phase == 2));
      chk("rnd halted", 32'(halted0), mhalt);
      chk("rnd count",  32'(cnt0),    mcnt);
      chk("rnd valid",  32'(valid0),  32'(ev));
      if (phase == 1) chk("rnd addr", 32'(address0), mpc);

      instr_ready = 1'($urandom);
      jump_en     = (($urandom % 4) == 0);
      jump_addr   = 5'($urandom);
      start       = (($urandom % 8) == 0);
      start_addr  = 5'($urandom);

      if (ev && instr_ready) begin
        chk("rnd pc_out", 32'(pc_out0), mpc);
        chk("rnd word",   32'(word0()), 32'(mem[mpc]));
        w = mem[mpc];
        mcnt = (mcnt < 63) ? mcnt + 1 : 63;
        if (w[17:16] == 2'b11) begin
          mhalt = 1; phase = 2;
        end else if (jump_en) begin
          mpc = jump_addr; pend = 2;
        end else if (mpc == 31) begin
          phase = 2;
        end else begin
          mpc = mpc + 1; pend = 2;
        end
      end else if (start && phase != 1) begin
        phase = 1; mpc = start_addr; mcnt = 0; mhalt = 0; pend = 2;
      end

      tick();
      if (pend > 0) pend--;
    end
    start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reader/sequencer for the 32 x 18-bit program memory.
- Drives the 5-bit `address`, samples the combinational `instruction` word, and holds it in an instruction register (IR).
- Splits the IR into opcode and four 4-bit fields and hands each word downstream over a valid/ready handshake.
- Owns the program counter (PC), jumps, HALT detection and end-of-program.

Parameters:
- ADDR_W, 5, address width; program depth is 2**ADDR_W.
- INSTR_W, 18, instruction width; must equal 2 + 4*4.
- WRAP_EN, 0, 1 = PC wraps from the last address to 0 and continues; 0 = stop after the last address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin fetching from start_addr (ignored unless IDLE or DONE).
- start_addr  in  5  first PC value.
- address  out  5  to program memory; always equals PC.
- instruction  in  18  from program memory (combinational read).
- instr_valid  out  1  IR holds an unconsumed word.
- instr_ready  in  1  downstream accepts the word this cycle.
- opcode  out  2  IR[17:16].
- fld_a  out  4  IR[15:12].
- fld_b  out  4  IR[11:8].
- fld_c  out  4  IR[7:4].
- fld_d  out  4  IR[3:0].
- pc_out  out  5  address of the word currently held in IR.
- jump_en  in  1  sampled only in the accept cycle (instr_valid & instr_ready).
- jump_addr  in  5  next PC when jump_en is taken.
- busy  out  1  high in FETCH or HOLD.
- done  out  1  high in DONE.
- halted  out  1  sticky; set when a HALT word is accepted, cleared by start or rst.
- instr_count  out  6  words accepted since the last start; saturates at 63.

Behaviour:
- Reset values:
  - state IDLE; PC = 0; IR = 0 (so opcode and all fields read 0).
  - pc_out = 0, instr_valid = 0, busy = 0, done = 0, halted = 0, instr_count = 0.
- Reset has priority over every other input. Reset mid-operation abandons the current word with no accept.
- `address` is PC combinationally, with no extra register.
- States:
  - IDLE: start -> PC <= start_addr, instr_count <= 0, halted <= 0, go FETCH.
  - FETCH: IR <= instruction, pc_out <= PC, instr_valid <= 1, go HOLD. Latency from start to instr_valid is 2 clock edges.
  - HOLD: instr_valid = 1; IR and all field outputs stay stable while instr_ready = 0.
    - On accept: instr_count++ (saturating).
    - If opcode == 2'b11 (HALT): halted <= 1, go DONE; jump_en is ignored.
    - Else if jump_en: PC <= jump_addr, go FETCH.
    - Else if PC == 31 and WRAP_EN == 0: go DONE.
    - Else: PC <= PC + 1 (modulo 32), go FETCH.
    - instr_valid falls on the edge after the accept.
  - DONE: instr_valid = 0; IR is held. start behaves as in IDLE.
- Throughput: one word per 2 cycles when instr_ready is held high (a FETCH bubble between words).
- start while busy is ignored.
- A jump to the current PC is legal: the same word is re-fetched and re-issued.
- instr_ready while instr_valid = 0 has no effect.

Decomposition:
- Shared package (fetch_pkg):
  - OP_W = 2, FLD_W = 4.
  - OP_HALT = 2'b11.
  - state encoding: IDLE = 0, FETCH = 1, HOLD = 2, DONE = 3.
  - field bit-position constants.
- One natural sub-module, instr_field_split: purely combinational IR -> opcode/fld_a..d. It is reused by the future execute stage.
- PC, FSM and counter stay in the top module.

Test Plan:
- Reset, then start with start_addr = 0 and instr_ready = 1, program memory attached:
  - first valid at edge 2 after start.
  - opcode = 1, fld_a = 15, fld_b = 1, fld_c = 1, fld_d = 2, pc_out = 0.
  - next word has pc_out = 1, opcode = 0, fld_a = 7, fld_d = 3.
- Full run with WRAP_EN = 0 and instr_ready = 1:
  - 32 accepts, then done = 1 and instr_count = 32.
  - last word has opcode = 1, fld_a = 15, fld_b = 15, fld_c = 1, fld_d = 2, pc_out = 31.
- Backpressure: hold instr_ready = 0 for 5 cycles on address 3 -> instr_valid stays 1 and IR stays 18'b10_0011_0001_0001_0010 throughout; PC does not advance; accept occurs on the first ready cycle.
- Jump: accept at pc_out = 4 with jump_en = 1 and jump_addr = 24 -> next word has pc_out = 24, opcode = 1, fld_a = 3, fld_b = 13.
- HALT: stub memory returns 18'b11_0000_0000_0000_0000 at address 2 -> after its accept, halted = 1, done = 1 and instr_count = 3; a subsequent start clears halted and refetches.
- Reset mid-HOLD at pc_out = 10 -> next cycle all outputs are at reset values; start with start_addr = 30 and WRAP_EN = 1 -> the sequence 30, 31, 0, 1 appears on pc_out.
